// File: rtl/cache_ctrl_nway_if.sv
// CPU / array / memory-adapter bundle for the N-way cache controller.
// hit_count/miss_count exist only when CACHE_PERF_CNT_EN is defined.
interface cache_ctrl_nway_if #(
    parameter int WAYS  = 2,
    parameter int CNT_W = 32
);
    localparam int WAY_W = $clog2(WAYS);

    logic             cpu_read;
    logic             cpu_write;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_way;
    logic [WAYS-1:0]  is_valid;
    logic [WAYS-1:0]  is_dirty;
    logic             mem_ack;

    logic             cpu_ready;
    logic [WAYS-1:0]  load_data;
    logic [WAYS-1:0]  load_tag;
    logic [WAYS-1:0]  set_valid;
    logic [WAYS-1:0]  set_dirty;
    logic [WAYS-1:0]  clr_dirty;
    logic             data_in_select;
    logic             lru_load;
    logic [WAY_W-1:0] lru_way;
    logic             mem_read;
    logic             mem_write;
    logic             busy;
    logic             error;
`ifdef CACHE_PERF_CNT_EN
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;
`endif

    modport master (
`ifdef CACHE_PERF_CNT_EN
        input  hit_count, miss_count,
`endif
        output cpu_read, cpu_write, hit, hit_way, victim_way,
        output is_valid, is_dirty, mem_ack,
        input  cpu_ready, load_data, load_tag, set_valid, set_dirty,
        input  clr_dirty, data_in_select, lru_load, lru_way,
        input  mem_read, mem_write, busy, error
    );

    modport slave (
`ifdef CACHE_PERF_CNT_EN
        output hit_count, miss_count,
`endif
        input  cpu_read, cpu_write, hit, hit_way, victim_way,
        input  is_valid, is_dirty, mem_ack,
        output cpu_ready, load_data, load_tag, set_valid, set_dirty,
        output clr_dirty, data_in_select, lru_load, lru_way,
        output mem_read, mem_write, busy, error
    );
endinterface

// File: rtl/cache_ctrl_nway.sv
// N-way write-back/write-allocate cache controller FSM, all outputs registered.
// Optional saturating hit/miss counters under CACHE_PERF_CNT_EN.
module cache_ctrl_nway #(
    parameter int WAYS        = 2,
    parameter int WAY_W       = $clog2(WAYS),
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input logic              clk,
    input logic              rst,
    cache_ctrl_nway_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CHECK     = 3'd1;
    localparam logic [2:0] S_WRITEBACK = 3'd2;
    localparam logic [2:0] S_REFILL    = 3'd3;
    localparam logic [2:0] S_INSTALL   = 3'd4;
    localparam logic [2:0] S_ERROR     = 3'd5;

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    logic [2:0]       state_q, state_d;
    logic             wr_q, wr_d;
    logic [WAY_W-1:0] vic_q, vic_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;

    logic             cpu_ready_q, cpu_ready_d;
    logic [WAYS-1:0]  load_data_q, load_data_d;
    logic [WAYS-1:0]  load_tag_q, load_tag_d;
    logic [WAYS-1:0]  set_valid_q, set_valid_d;
    logic [WAYS-1:0]  set_dirty_q, set_dirty_d;
    logic [WAYS-1:0]  clr_dirty_q, clr_dirty_d;
    logic             dsel_q, dsel_d;
    logic             lru_load_q, lru_load_d;
    logic [WAY_W-1:0] lru_way_q, lru_way_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             busy_q, busy_d;
    logic             error_q, error_d;

    logic hit_ok, vic_dirty, timed_out;

    function automatic logic [WAYS-1:0] onehot(input logic [WAY_W-1:0] w);
        return WAYS'(1) << w;
    endfunction

    assign hit_ok    = bus.hit && bus.is_valid[bus.hit_way];
    assign vic_dirty = bus.is_valid[bus.victim_way] && bus.is_dirty[bus.victim_way];
    assign timed_out = (tcnt_q == TW'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        vic_d       = vic_q;
        tcnt_d      = tcnt_q;
        cpu_ready_d = 1'b0;
        load_data_d = '0;
        load_tag_d  = '0;
        set_valid_d = '0;
        set_dirty_d = '0;
        clr_dirty_d = '0;
        dsel_d      = 1'b0;
        lru_load_d  = 1'b0;
        lru_way_d   = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        error_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cpu_write) begin
                    wr_d    = 1'b1;
                    state_d = S_CHECK;
                end else if (bus.cpu_read) begin
                    wr_d    = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (hit_ok) begin
                    lru_load_d  = 1'b1;
                    lru_way_d   = bus.hit_way;
                    cpu_ready_d = 1'b1;
                    if (wr_q) begin
                        load_data_d = onehot(bus.hit_way);
                        set_dirty_d = onehot(bus.hit_way);
                    end
                    state_d = S_IDLE;
                end else begin
                    vic_d  = bus.victim_way;
                    tcnt_d = '0;
                    if (vic_dirty) begin
                        mem_write_d = 1'b1;
                        state_d     = S_WRITEBACK;
                    end else begin
                        mem_read_d = 1'b1;
                        dsel_d     = 1'b1;
                        state_d    = S_REFILL;
                    end
                end
            end
            S_WRITEBACK: begin
                if (bus.mem_ack) begin
                    clr_dirty_d = onehot(vic_q);
                    mem_read_d  = 1'b1;
                    dsel_d      = 1'b1;
                    tcnt_d      = '0;
                    state_d     = S_REFILL;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    mem_write_d = 1'b1;
                    tcnt_d      = tcnt_q + 1'b1;
                end
            end
            S_REFILL: begin
                if (bus.mem_ack) begin
                    load_data_d = onehot(vic_q);
                    load_tag_d  = onehot(vic_q);
                    set_valid_d = onehot(vic_q);
                    dsel_d      = 1'b1;
                    state_d     = S_INSTALL;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    mem_read_d = 1'b1;
                    dsel_d     = 1'b1;
                    tcnt_d     = tcnt_q + 1'b1;
                end
            end
            S_INSTALL: begin
                lru_load_d  = 1'b1;
                lru_way_d   = vic_q;
                cpu_ready_d = 1'b1;
                // merge the CPU word over the freshly refilled line
                if (wr_q) begin
                    load_data_d = onehot(vic_q);
                    set_dirty_d = onehot(vic_q);
                end
                state_d = S_IDLE;
            end
            S_ERROR: begin
                state_d = S_IDLE;
            end
            default: begin
                error_d = 1'b1;
                state_d = S_ERROR;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            vic_q       <= '0;
            tcnt_q      <= '0;
            cpu_ready_q <= 1'b0;
            load_data_q <= '0;
            load_tag_q  <= '0;
            set_valid_q <= '0;
            set_dirty_q <= '0;
            clr_dirty_q <= '0;
            dsel_q      <= 1'b0;
            lru_load_q  <= 1'b0;
            lru_way_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            vic_q       <= vic_d;
            tcnt_q      <= tcnt_d;
            cpu_ready_q <= cpu_ready_d;
            load_data_q <= load_data_d;
            load_tag_q  <= load_tag_d;
            set_valid_q <= set_valid_d;
            set_dirty_q <= set_dirty_d;
            clr_dirty_q <= clr_dirty_d;
            dsel_q      <= dsel_d;
            lru_load_q  <= lru_load_d;
            lru_way_q   <= lru_way_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign bus.cpu_ready      = cpu_ready_q;
    assign bus.load_data      = load_data_q;
    assign bus.load_tag       = load_tag_q;
    assign bus.set_valid      = set_valid_q;
    assign bus.set_dirty      = set_dirty_q;
    assign bus.clr_dirty      = clr_dirty_q;
    assign bus.data_in_select = dsel_q;
    assign bus.lru_load       = lru_load_q;
    assign bus.lru_way        = lru_way_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.busy           = busy_q;
    assign bus.error          = error_q;

`ifdef CACHE_PERF_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_CHECK) begin
            if (hit_ok && !(&hit_cnt_q))
                hit_cnt_q <= hit_cnt_q + 1'b1;
            if (!hit_ok && !(&miss_cnt_q))
                miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif
endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Scoreboard bench for cache_ctrl_nway (WAYS=4, MEM_TIMEOUT=8).
// Stimulus queues expected pulse events; a negedge monitor pops and compares.
module tb_cache_ctrl_nway;
    localparam int WAYS = 4;
    localparam int TO   = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_ctrl_nway_if #(.WAYS(WAYS), .CNT_W(16)) bus ();

    cache_ctrl_nway #(
        .WAYS(WAYS), .MEM_TIMEOUT(TO), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct packed {
        logic       rdy, err, lru, mr, mw, busy, dsel;
        logic [1:0] lway;
        logic [3:0] ld, lt, sv, sd, cd;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  m_hits   = 0;
    int  m_misses = 0;

    function automatic ev_t sample();
        ev_t a;
        a.rdy  = bus.cpu_ready;
        a.err  = bus.error;
        a.lru  = bus.lru_load;
        a.mr   = bus.mem_read;
        a.mw   = bus.mem_write;
        a.busy = bus.busy;
        a.dsel = bus.data_in_select;
        a.lway = bus.lru_way;
        a.ld   = bus.load_data;
        a.lt   = bus.load_tag;
        a.sv   = bus.set_valid;
        a.sd   = bus.set_dirty;
        a.cd   = bus.clr_dirty;
        return a;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: any pulse output is an event that must match the queue head
    always @(negedge clk) begin
        ev_t a, e;
        if (!rst) begin
            a = sample();
            if (a.rdy || a.err || a.lru || (|a.ld) || (|a.lt) ||
                (|a.sv) || (|a.sd) || (|a.cd)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event actual=%h required=none", a);
                end else begin
                    e = exp_q.pop_front();
                    if (e.err) begin
                        a.dsel = 1'b0;
                        e.dsel = 1'b0;
                    end
                    if (a !== e) begin
                        failures++;
                        $display("FAIL event actual=%h required=%h", a, e);
                    end
                end
            end
        end
    end

    // Reference model: expected pulse events of one request
    task automatic model(input bit wr, input bit h, input int hw,
                         input logic [3:0] iv, input logic [3:0] id,
                         input int v, input int to_ph);
        ev_t e;
        logic [3:0] vm;
        vm = 4'b0001 << v;
        if (h && iv[hw]) begin
            m_hits++;
            e = '0;
            e.rdy = 1'b1;
            e.lru = 1'b1;
            e.lway = 2'(hw);
            if (wr) begin
                e.ld = 4'b0001 << hw;
                e.sd = 4'b0001 << hw;
            end
            exp_q.push_back(e);
            return;
        end
        m_misses++;
        if (iv[v] && id[v]) begin
            e = '0;
            if (to_ph == 1) begin
                e.err = 1'b1;
                e.busy = 1'b1;
                exp_q.push_back(e);
                return;
            end
            e.cd = vm;
            e.mr = 1'b1;
            e.dsel = 1'b1;
            e.busy = 1'b1;
            exp_q.push_back(e);
        end
        e = '0;
        if (to_ph == 2) begin
            e.err = 1'b1;
            e.busy = 1'b1;
            exp_q.push_back(e);
            return;
        end
        e.ld = vm;
        e.lt = vm;
        e.sv = vm;
        e.dsel = 1'b1;
        e.busy = 1'b1;
        exp_q.push_back(e);
        e = '0;
        e.rdy = 1'b1;
        e.lru = 1'b1;
        e.lway = 2'(v);
        if (wr) begin
            e.ld = vm;
            e.sd = vm;
        end
        exp_q.push_back(e);
    endtask

    task automatic run_txn(input bit wr, input bit both, input bit h,
                           input int hw, input logic [3:0] iv,
                           input logic [3:0] id, input int v,
                           input int lw, input int lr, input int to_ph);
        int  cw, cr, dc;
        bit  done, got_err, is_hit, dirty;
        is_hit = h && iv[hw];
        dirty  = iv[v] && id[v];
        model(wr, h, hw, iv, id, v, to_ph);
        @(posedge clk);
        #1;
        bus.mem_ack    = 1'b0;
        bus.cpu_write  = wr;
        bus.cpu_read   = !wr || both;
        bus.hit        = h;
        bus.hit_way    = 2'(hw);
        bus.victim_way = 2'(v);
        bus.is_valid   = iv;
        bus.is_dirty   = id;
        cw = 0; cr = 0; dc = -1;
        done = 1'b0; got_err = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (bus.cpu_ready || bus.error) begin
                done = 1'b1;
                got_err = bus.error;
                dc = c;
                bus.cpu_read  = 1'b0;
                bus.cpu_write = 1'b0;
                bus.cpu_read  = $urandom_range(0, 1) == 0 ? 1'b0 : 1'b0;
            end else begin
                if (bus.mem_write) begin
                    cw++;
                    if (to_ph != 1 && cw == lw) bus.mem_ack = 1'b1;
                end
                if (bus.mem_read) begin
                    cr++;
                    if (!bus.data_in_select)
                        chk("refill_dsel", 0, 1);
                    if (to_ph != 2 && cr == lr) bus.mem_ack = 1'b1;
                end
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout actual=none required=cpu_ready_or_error");
        end
        if (is_hit) begin
            chk("hit_latency", dc, 1);
            chk("hit_mem_write", cw, 0);
            chk("hit_mem_read", cr, 0);
        end else begin
            chk("wb_hold", cw, !dirty ? 0 : (to_ph == 1 ? TO : lw));
            chk("rf_hold", cr, (dirty && to_ph == 1) ? 0 :
                               (to_ph == 2 ? TO : lr));
            chk("error_seen", int'(got_err),
                int'((dirty && to_ph == 1) || to_ph == 2));
        end
        if (got_err) begin
            @(posedge clk);
            #1;
            chk("busy_after_err", int'(bus.busy), 0);
        end
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.mem_ack = ($urandom_range(0, 2) == 0);
        end
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
    endtask

    task automatic reset_mid_refill();
        int n;
        @(posedge clk);
        #1;
        bus.cpu_read   = 1'b1;
        bus.cpu_write  = 1'b0;
        bus.hit        = 1'b0;
        bus.victim_way = 2'd2;
        bus.is_valid   = 4'b0000;
        bus.is_dirty   = 4'b0000;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(posedge clk);
            #1;
            if (bus.mem_read) n++;
        end
        chk("reached_refill", n, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", int'(sample()), 0);
        bus.cpu_read = 1'b0;
        m_hits = 0;
        m_misses = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit wr, h;
        int hw, v, tp;
        logic [3:0] iv, id;
        rst = 1'b1;
        bus.cpu_read = 1'b0;
        bus.cpu_write = 1'b0;
        bus.hit = 1'b0;
        bus.hit_way = '0;
        bus.victim_way = '0;
        bus.is_valid = '0;
        bus.is_dirty = '0;
        bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", int'(sample()), 0);
        rst = 1'b0;
        idle_gap(2);

        run_txn(1'b0, 1'b0, 1'b1, 2, 4'b0100, 4'b0000, 0, 1, 1, 0);
        run_txn(1'b1, 1'b0, 1'b1, 1, 4'b0010, 4'b0000, 0, 1, 1, 0);
        run_txn(1'b0, 1'b0, 1'b0, 0, 4'b1000, 4'b1000, 3, 5, 5, 0);
        run_txn(1'b1, 1'b0, 1'b0, 0, 4'b0000, 4'b0000, 0, 3, 3, 0);
        run_txn(1'b0, 1'b0, 1'b0, 0, 4'b0000, 4'b0000, 1, 1, 1, 2);
        run_txn(1'b1, 1'b1, 1'b0, 0, 4'b0100, 4'b0100, 2, 2, 2, 1);
        idle_gap(3);
        reset_mid_refill();
        run_txn(1'b0, 1'b0, 1'b1, 3, 4'b1000, 4'b0000, 0, 1, 1, 0);

        for (int t = 0; t < 60; t++) begin
            wr = $urandom_range(0, 1) == 1;
            h  = $urandom_range(0, 1) == 1;
            hw = int'($urandom_range(0, 3));
            v  = int'($urandom_range(0, 3));
            iv = 4'($urandom_range(0, 15));
            id = 4'($urandom_range(0, 15));
            tp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_txn(wr, $urandom_range(0, 1) == 1, h, hw, iv, id, v,
                    int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), tp);
            idle_gap(int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
`ifdef CACHE_PERF_CNT_EN
        chk("hit_count", int'(bus.hit_count), m_hits);
        chk("miss_count", int'(bus.miss_count), m_misses);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
